// File: rtl/mem_pkg.sv
// Shared types and constants for the unified instruction/data memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // Byte offset bits below the word index of a byte address.
  localparam int WORD_OFFSET_BITS = 2;

endpackage

// File: rtl/mem_array_1rw.sv
// Single-port word array: synchronous write enable, asynchronous read on the same index.
module mem_array_1rw #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // NOTE: storage arrays get no reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Target end of the control unit's memory interface: one request at a time,
// configurable read/write wait states, single-cycle response pulse.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int RD_LAT      = 2,
  parameter int WR_LAT      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W   = $clog2(DEPTH_WORDS);
  localparam int WIDX_W  = ADDR_W - WORD_OFFSET_BITS;
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0]  RD_CNT  = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]  WR_CNT  = CNT_W'(WR_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [WIDX_W-1:0] DEPTH_L = WIDX_W'(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              addr_err;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;

  // Misaligned or beyond the array: decided once, at acceptance.
  assign addr_err = (req_addr[WORD_OFFSET_BITS-1:0] != '0) ||
                    (req_addr[ADDR_W-1:WORD_OFFSET_BITS] >= DEPTH_L);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    err_d     = err_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          we_d    = req_we;
          err_d   = addr_err;
          idx_d   = req_addr[WORD_OFFSET_BITS +: IDX_W];
          wdata_d = req_wdata;
          cnt_d   = req_we ? WR_CNT : RD_CNT;
          state_d = (cnt_d == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  // Writes commit on the edge that closes RESP, so a reset before then drops them.
  assign mem_we = rsp_valid && we_q && !err_q;

  mem_array_1rw #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? mem_rdata : '0;
  assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances cover default, short-read/long-write
// and long-read latency configurations.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst       [3];
  logic        req_valid [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];
  logic        busy      [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  int pulse_cnt [3] = '{0, 0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid[i] === 1'b1) pulse_cnt[i] <= pulse_cnt[i] + 1;
    end
  end

  mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(64), .RD_LAT(2), .WR_LAT(1)) dut0 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0]));

  mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(64), .RD_LAT(1), .WR_LAT(3)) dut1 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1]));

  mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(64), .RD_LAT(5), .WR_LAT(1)) dut2 (
    .clk(clk), .reset(rst[2]), .req_valid(req_valid[2]), .req_we(req_we[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_ready(req_ready[2]),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]), .busy(busy[2]));

  // Presents one request, waits for acceptance and the response (both bounded).
  // lat counts falling edges after the acceptance edge until rsp_valid; -1 if none.
  // rdy_ok clears if req_ready is high or busy low while the transaction is outstanding.
  task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit hold,
                        output int lat, output logic [31:0] rdata,
                        output logic err, output bit rdy_ok);
    int n;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!hold) req_valid[d] = 1'b0;
    lat    = -1;
    rdata  = 'x;
    err    = 1'bx;
    rdy_ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (req_ready[d] !== 1'b0 || busy[d] !== 1'b1) rdy_ok = 1'b0;
      if (rsp_valid[d] === 1'b1) begin
        lat   = k;
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0;
      req_addr[i] = '0; req_wdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0 ||
          rsp_rdata[0] !== 32'h0 || rsp_err[0] !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: ready=%b valid=%b busy=%b rdata=%h err=%b, expected 1 0 0 00000000 0",
                 c, req_ready[0], rsp_valid[0], busy[0], rsp_rdata[0], rsp_err[0]);
      end
    end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er; bit ok;
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, lat, rd, er, ok);
    checks++;
    if (lat !== 1 || er !== 1'b0 || rd !== 32'h0 || !ok) begin
      errors++;
      $display("FAIL write_0x10: lat=%0d err=%b rdata=%h rdy_ok=%0d, expected lat=1 err=0 rdata=0 rdy_ok=1",
               lat, er, rd, ok);
    end
    do_req(0, 1'b0, 32'h10, 32'h0, 1'b0, lat, rd, er, ok);
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF || !ok) begin
      errors++;
      $display("FAIL read_0x10: lat=%0d err=%b rdata=%h rdy_ok=%0d, expected lat=2 err=0 rdata=deadbeef rdy_ok=1",
               lat, er, rd, ok);
    end
    // Last legal word.
    do_req(0, 1'b1, 32'hFC, 32'h0BADF00D, 1'b0, lat, rd, er, ok);
    do_req(0, 1'b0, 32'hFC, 32'h0, 1'b0, lat, rd, er, ok);
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL read_0xfc: lat=%0d err=%b rdata=%h, expected lat=2 err=0 rdata=0badf00d", lat, er, rd);
    end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er; bit ok;
    do_req(0, 1'b1, 32'h0, 32'hCAFEF00D, 1'b0, lat, rd, er, ok);
    do_req(0, 1'b0, 32'h12, 32'h0, 1'b0, lat, rd, er, ok);
    checks++;
    if (lat !== 2 || er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL misaligned_read: lat=%0d err=%b rdata=%h, expected lat=2 err=1 rdata=0", lat, er, rd);
    end
    do_req(0, 1'b1, 32'h100, 32'h1234, 1'b0, lat, rd, er, ok);
    checks++;
    if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL range_write: lat=%0d err=%b rdata=%h, expected lat=1 err=1 rdata=0", lat, er, rd);
    end
    do_req(0, 1'b0, 32'h0, 32'h0, 1'b0, lat, rd, er, ok);
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL read_after_err: lat=%0d err=%b rdata=%h, expected lat=2 err=0 rdata=cafef00d", lat, er, rd);
    end
    // A misaligned write must not land on its word either.
    do_req(0, 1'b1, 32'h2, 32'h5555AAAA, 1'b0, lat, rd, er, ok);
    do_req(0, 1'b0, 32'h0, 32'h0, 1'b0, lat, rd, er, ok);
    checks++;
    if (rd !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL misaligned_write_leak: rdata=%h, expected cafef00d", rd);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic er; bit ok;
    int acc [3];
    int p0;
    logic [31:0] exp_data [3] = '{32'hCAFEF00D, 32'h44444444, 32'h88888888};
    do_req(0, 1'b1, 32'h4, 32'h44444444, 1'b0, lat, rd, er, ok);
    do_req(0, 1'b1, 32'h8, 32'h88888888, 1'b0, lat, rd, er, ok);
    @(negedge clk);
    p0 = pulse_cnt[0];
    for (int i = 0; i < 3; i++) begin
      do_req(0, 1'b0, 32'(i * 4), 32'h0, (i < 2), lat, rd, er, ok);
      acc[i] = acc_cyc;
      checks++;
      if (lat !== 2 || er !== 1'b0 || rd !== exp_data[i]) begin
        errors++;
        $display("FAIL b2b_read%0d: lat=%0d err=%b rdata=%h, expected lat=2 err=0 rdata=%h",
                 i, lat, er, rd, exp_data[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (acc[i] - acc[i-1] !== 3) begin
        errors++;
        $display("FAIL b2b_spacing%0d: %0d cycles, expected 3", i, acc[i] - acc[i-1]);
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (pulse_cnt[0] - p0 !== 3) begin
      errors++;
      $display("FAIL b2b_pulses: %0d, expected 3", pulse_cnt[0] - p0);
    end
  endtask

  task automatic test_reset_mid_write();
    int lat; logic [31:0] rd; logic er; bit ok;
    int p1;
    do_req(1, 1'b1, 32'h20, 32'h11111111, 1'b0, lat, rd, er, ok);
    checks++;
    if (lat !== 3 || er !== 1'b0) begin
      errors++;
      $display("FAIL wr_lat3: lat=%0d err=%b, expected lat=3 err=0", lat, er);
    end
    @(negedge clk);
    checks++;
    if (req_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_write_ready: req_ready=%b, expected 1", req_ready[1]);
    end
    p1 = pulse_cnt[1];
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h20; req_wdata[1] = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_write_abort: busy=%b ready=%b, expected busy=0 ready=1", busy[1], req_ready[1]);
    end
    rst[1] = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (pulse_cnt[1] !== p1) begin
      errors++;
      $display("FAIL mid_write_no_rsp: %0d pulses, expected 0", pulse_cnt[1] - p1);
    end
    do_req(1, 1'b0, 32'h20, 32'h0, 1'b0, lat, rd, er, ok);
    checks++;
    if (lat !== 1 || er !== 1'b0 || rd !== 32'h11111111) begin
      errors++;
      $display("FAIL read_after_abort: lat=%0d err=%b rdata=%h, expected lat=1 err=0 rdata=11111111",
               lat, er, rd);
    end
  endtask

  task automatic test_latency_sweep();
    int lat; logic [31:0] rd; logic er; bit ok;
    do_req(2, 1'b1, 32'h3C, 32'h13572468, 1'b0, lat, rd, er, ok);
    checks++;
    if (lat !== 1 || er !== 1'b0) begin
      errors++;
      $display("FAIL rd5_write: lat=%0d err=%b, expected lat=1 err=0", lat, er);
    end
    do_req(2, 1'b0, 32'h3C, 32'h0, 1'b0, lat, rd, er, ok);
    checks++;
    if (lat !== 5 || er !== 1'b0 || rd !== 32'h13572468 || !ok) begin
      errors++;
      $display("FAIL rd5_read: lat=%0d err=%b rdata=%h rdy_ok=%0d, expected lat=5 err=0 rdata=13572468 rdy_ok=1",
               lat, er, rd, ok);
    end
    do_req(1, 1'b0, 32'h41, 32'h0, 1'b0, lat, rd, er, ok);
    checks++;
    if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL rd1_err_read: lat=%0d err=%b rdata=%h, expected lat=1 err=1 rdata=0", lat, er, rd);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_errors();
    test_back_to_back();
    test_reset_mid_write();
    test_latency_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle ARM datapath: the target end of the control unit's unified instruction/data memory interface.
- Accepts one read or write request at a time from the initiator (fetch, MEMRD, MEMWR). Holds the word array, applies configurable wait states, and returns a single-cycle response.
- Lets the control FSM stall on rsp_valid instead of assuming single-cycle memory.

Parameters:
- DATA_W, 32, data word width in bits
- ADDR_W, 32, byte-address width
- DEPTH_WORDS, 64, number of words in the array; legal word indices are 0..DEPTH_WORDS-1
- RD_LAT, 2, cycles from read acceptance to rsp_valid; must be >= 1
- WR_LAT, 1, cycles from write acceptance to commit and rsp_valid; must be >= 1

Ports:
- clk  in  1  clock
- reset  in  1  reset
- req_valid  in  1  initiator presents a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address; word index = req_addr[ADDR_W-1:2]
- req_wdata  in  DATA_W  write data
- req_ready  out  1  responder can accept; transfer occurs when req_valid && req_ready at a rising edge
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data; valid only while rsp_valid
- rsp_err  out  1  request was misaligned or out of range; valid only while rsp_valid
- busy  out  1  transaction outstanding (state != IDLE)

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset values:
  - state = IDLE, counter = 0.
  - req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
  - Array contents are NOT reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On acceptance: capture we/addr/wdata into holding registers and load counter = (we ? WR_LAT : RD_LAT) - 1.
  - Go to RESP if the loaded counter is 0, else WAIT.
  - With no req_valid, stay in IDLE.
- WAIT:
  - req_ready = 0.
  - Decrement counter each cycle; go to RESP when counter reaches 0 (i.e. on the edge where counter==1 decrements to 0... implemented as: in WAIT, if counter==1 → RESP, else counter--).
- RESP:
  - req_ready = 0, rsp_valid = 1 for exactly this cycle.
  - Next state is always IDLE.
- Latency: rsp_valid is asserted exactly LAT cycles after the acceptance edge (LAT = RD_LAT or WR_LAT).
- Throughput: at most one transaction per LAT+1 cycles, since req_ready is low in WAIT and RESP.
- Error check, done at acceptance:
  - err = (addr[1:0] != 0) || (addr[ADDR_W-1:2] >= DEPTH_WORDS).
  - On error: array untouched, rsp_rdata = 0, rsp_err = 1.
- Write:
  - Array word updated at the clock edge that ends the RESP cycle (commit at rsp).
  - rsp_rdata = 0 on writes.
- Read:
  - rsp_rdata = array[held index], sampled combinationally during RESP.
  - A write committed by an earlier transaction is always visible.
- Request signals are ignored while req_ready = 0; the initiator must hold req_valid until accepted.
- Reset mid-transaction:
  - Abort immediately and return to IDLE.
  - An uncommitted write is dropped; no rsp_valid is produced.
- rsp_rdata and rsp_err are driven to 0 whenever rsp_valid = 0.

Decomposition:
- Shared package mem_pkg: state enum (IDLE, WAIT, RESP) and a WORD_OFFSET_BITS = 2 constant.
- One natural sub-module: mem_array_1rw, a DEPTH_WORDS x DATA_W single-port array with synchronous write enable and asynchronous read.
- The FSM, counter, error check and holding registers stay in mem_responder.

Test Plan:
- Reset then idle: hold reset 3 cycles, release → req_ready=1, rsp_valid=0, busy=0 every cycle for 10 cycles.
- Write then read: write 0xDEADBEEF @0x10; rsp_valid 1 cycle after acceptance, rsp_err=0. Read @0x10 → rsp_valid exactly 2 cycles after acceptance with rsp_rdata=0xDEADBEEF; req_ready=0 for the 2 intervening cycles.
- Errors: read @0x12 → rsp_err=1, rsp_rdata=0. Write 0x1234 @0x100 (index 64 ≥ DEPTH) → rsp_err=1. A following read @0x0 returns the prior contents unchanged.
- Back-to-back: req_valid held high with reads @0x0, @0x4, @0x8 → acceptances spaced RD_LAT+1 = 3 cycles apart, three rsp_valid pulses, no dropped or duplicated responses.
- Reset mid-write: write 0xA5A5A5A5 @0x20 with WR_LAT=3, assert reset 1 cycle after acceptance → no rsp_valid; a read @0x20 afterwards returns the pre-write value.
- Latency parameter sweep: RD_LAT=1 and RD_LAT=5 → rsp_valid lands exactly 1 and 5 cycles after acceptance respectively.
